// File: rtl/lcd_timing_pkg.sv
// Shared panel timing sets and geometry helpers for the LCD raster timing generator.
package lcd_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_front;
        int h_sync;
        int h_back;
        int v_active;
        int v_front;
        int v_sync;
        int v_back;
    } panel_timing_t;

    localparam panel_timing_t PANEL_800X480 = '{
        h_active: 800, h_front: 40, h_sync: 48, h_back: 40,
        v_active: 480, v_front: 13, v_sync: 3,  v_back: 32
    };

    localparam panel_timing_t PANEL_640X480 = '{
        h_active: 640, h_front: 16, h_sync: 96, h_back: 48,
        v_active: 480, v_front: 10, v_sync: 2,  v_back: 33
    };

    function automatic int timing_total(input int active, input int front,
                                        input int sync, input int back);
        return active + front + sync + back;
    endfunction

    // Never narrower than one bit, so a divide-by-one divider still has a register.
    function automatic int counter_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Raster timing bus between the timing generator (master) and the pixel chain (slave).
interface lcd_timing_gen_if #(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10
);
    logic               enable;
    logic               tick;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic               active;
    logic               next_frame;
    logic               hs_n;
    logic               vs_n;
    logic               data_enable;

    modport master (
        input  enable,
        output tick, x, y, active, next_frame, hs_n, vs_n, data_enable
    );

    modport slave (
        output enable,
        input  tick, x, y, active, next_frame, hs_n, vs_n, data_enable
    );
endinterface

// File: rtl/lcd_delay_line.sv
// Tick-gated shift register that aligns control (or colour) bits with pixel pipeline latency.
module lcd_delay_line #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clock, reset, advance};
        assign out = in;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        // NOTE: the stages are a handful of flops, not a RAM, so they take a reset value like any other state.
        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VALUE;
            end else if (advance) begin
                stage_q[0] <= in;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign out = stage_q[DEPTH-1];
    end
endmodule

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD raster timing generator: pixel tick divider, h/v counters and
// sync/data-enable outputs delayed to match the downstream pixel pipeline.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int CLOCK_DIVIDE   = 2,
    parameter int H_ACTIVE       = PANEL_800X480.h_active,
    parameter int H_FRONT        = PANEL_800X480.h_front,
    parameter int H_SYNC         = PANEL_800X480.h_sync,
    parameter int H_BACK         = PANEL_800X480.h_back,
    parameter int V_ACTIVE       = PANEL_800X480.v_active,
    parameter int V_FRONT        = PANEL_800X480.v_front,
    parameter int V_SYNC         = PANEL_800X480.v_sync,
    parameter int V_BACK         = PANEL_800X480.v_back,
    parameter int PIPELINE_DELAY = 2,
    parameter int X_WIDTH        = 10,
    parameter int Y_WIDTH        = 10
) (
    input  logic             clock,
    input  logic             reset,
    lcd_timing_gen_if.master bus
);
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int H_W     = counter_width(H_TOTAL);
    localparam int V_W     = counter_width(V_TOTAL);
    localparam int DIV_W   = counter_width(CLOCK_DIVIDE);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_VIS      = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]   H_SYNC_ON  = H_W'(H_ACTIVE + H_FRONT);
    localparam logic [H_W-1:0]   H_SYNC_OFF = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_VIS      = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]   V_SYNC_ON  = V_W'(V_ACTIVE + V_FRONT);
    localparam logic [V_W-1:0]   V_SYNC_OFF = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        CLOCK_DIVIDE < 1 || PIPELINE_DELAY < 0 ||
        (X_WIDTH < 31 && (1 << X_WIDTH) < H_ACTIVE) ||
        (Y_WIDTH < 31 && (1 << Y_WIDTH) < V_ACTIVE)) begin : g_bad_params
        $error("lcd_timing_gen: zero timing count, CLOCK_DIVIDE < 1, or x/y too narrow");
    end

    logic [DIV_W-1:0]   div_q;
    logic [H_W-1:0]     h_q, h_next;
    logic [V_W-1:0]     v_q, v_next;
    logic               tick_q, next_frame_q, active_q, hs_raw_q, vs_raw_q;
    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q;
    logic               tick_now, h_wrap, v_wrap, active_next, hs_next, vs_next;
    logic [2:0]         delayed;

    // Everything below describes the position the counters move to on this tick.
    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        tick_now    = bus.enable && (div_q == DIV_LAST);
        h_wrap      = (h_q == H_LAST);
        v_wrap      = (v_q == V_LAST);
        h_next      = h_wrap ? '0 : h_q + H_W'(1);
        v_next      = v_q;
        if (h_wrap) v_next = v_wrap ? '0 : v_q + V_W'(1);
        active_next = (h_next < H_VIS) && (v_next < V_VIS);
        hs_next     = !((h_next >= H_SYNC_ON) && (h_next < H_SYNC_OFF));
        vs_next     = !((v_next >= V_SYNC_ON) && (v_next < V_SYNC_OFF));
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q        <= '0;
            h_q          <= '0;
            v_q          <= '0;
            tick_q       <= 1'b0;
            next_frame_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            active_q     <= 1'b1;
            hs_raw_q     <= 1'b1;
            vs_raw_q     <= 1'b1;
        end else begin
            tick_q       <= tick_now;
            next_frame_q <= tick_now && h_wrap && v_wrap;
            if (bus.enable) div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            if (tick_now) begin
                h_q      <= h_next;
                v_q      <= v_next;
                active_q <= active_next;
                x_q      <= active_next ? X_WIDTH'(h_next) : '0;
                y_q      <= active_next ? Y_WIDTH'(v_next) : '0;
                hs_raw_q <= hs_next;
                vs_raw_q <= vs_next;
            end
        end
    end

    // The registered raw signals enter the line on the same tick edge that replaces them.
    lcd_delay_line #(
        .WIDTH       (3),
        .DEPTH       (PIPELINE_DELAY),
        .RESET_VALUE (3'b110)
    ) u_sync_delay (
        .clock   (clock),
        .reset   (reset),
        .advance (tick_now),
        .in      ({hs_raw_q, vs_raw_q, active_q}),
        .out     (delayed)
    );

    assign bus.tick        = tick_q;
    assign bus.next_frame  = next_frame_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.active      = active_q;
    assign bus.hs_n        = delayed[2];
    assign bus.vs_n        = delayed[1];
    assign bus.data_enable = delayed[0];
endmodule
